// File: rtl/keypad_alu_pkg.sv
// Shared encodings for the keypad entry / register-bank ALU block.
package keypad_alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_IDLE = 2'd0;
    localparam key_state_t ST_DEB  = 2'd1;
    localparam key_state_t ST_HELD = 2'd2;

    // Key code layout: column in the upper pair, row in the lower pair.
    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_t;

    // Index of the lowest set bit of a 4-bit vector (0 when empty).
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_reg_alu_if.sv
// Host-side bus of the keypad register ALU: bank write/read control and ALU results.
interface keypad_reg_alu_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 2
);
    logic              wr_en;
    logic [AW-1:0]     addr_wr;
    logic [AW-1:0]     addr_a;
    logic [AW-1:0]     addr_b;
    logic [2:0]        op;
    logic [DATA_W-1:0] entry;
    logic [DATA_W-1:0] alu_out;
    logic              carry;
    logic              zero;

    modport master (
        output wr_en, addr_wr, addr_a, addr_b, op,
        input  entry, alu_out, carry, zero
    );

    modport slave (
        input  wr_en, addr_wr, addr_a, addr_b, op,
        output entry, alu_out, carry, zero
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounce FSM; emits one pulse per accepted press.
module keypad_scanner
    import keypad_alu_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code
);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    logic [DIV_W-1:0] div_q;
    logic             sample_c;
    logic             key_c;
    key_t             cur_c;
    key_state_t       state_q, state_nxt;
    key_t             cap_q, cap_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             valid_nxt;
    logic [3:0]       code_nxt;

    assign sample_c = (div_q == DIV_W'(SCAN_DIV - 1));
    assign key_c    = |row_in;
    assign cur_c    = {low_idx(col_out), low_idx(row_in)};

    // Column rotates on the last cycle of each slot, i.e. right after it is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            col_out <= 4'b0001;
        end else if (sample_c) begin
            div_q   <= '0;
            col_out <= {col_out[2:0], col_out[3]};
        end else begin
            div_q   <= div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cap_q     <= '0;
            cnt_q     <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state_q   <= state_nxt;
            cap_q     <= cap_nxt;
            cnt_q     <= cnt_nxt;
            key_valid <= valid_nxt;
            key_code  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cap_nxt   = cap_q;
        cnt_nxt   = cnt_q;
        valid_nxt = 1'b0;
        code_nxt  = key_code;
        if (sample_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_c) begin
                        cap_nxt = cur_c;
                        cnt_nxt = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            valid_nxt = 1'b1;
                            code_nxt  = cur_c;
                            state_nxt = ST_HELD;
                        end else begin
                            state_nxt = ST_DEB;
                        end
                    end
                end
                ST_DEB: begin
                    // Only samples of the captured column count toward debounce.
                    if (cur_c.col == cap_q.col) begin
                        if (key_c && (cur_c == cap_q)) begin
                            cnt_nxt = cnt_q + CNT_W'(1);
                            if (cnt_nxt == CNT_W'(DEBOUNCE)) begin
                                valid_nxt = 1'b1;
                                code_nxt  = cap_q;
                                state_nxt = ST_HELD;
                            end
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_HELD: begin
                    if ((cur_c.col == cap_q.col) && !row_in[cap_q.row]) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_reg_alu.sv
// Keypad hex entry feeding a small register bank with a registered two-operand ALU.
module keypad_reg_alu
    import keypad_alu_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NREG     = 4,
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic             key_valid,
    output logic [3:0]       key_code,
    keypad_reg_alu_if.slave  bus
);
    logic [DATA_W-1:0] entry_q;
    logic [DATA_W-1:0] bank_q [NREG];
    logic [DATA_W-1:0] a_c, b_c, res_c;
    logic [DATA_W:0]   wide_c;
    logic              carry_c;
    logic [DATA_W-1:0] alu_q;
    logic              carry_q;
    logic              zero_q;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    // A commit coinciding with a key stores the pre-shift entry and restarts entry at the new key.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else if (bus.wr_en && key_valid) begin
            entry_q <= DATA_W'(key_code);
        end else if (bus.wr_en) begin
            entry_q <= '0;
        end else if (key_valid) begin
            entry_q <= {entry_q[DATA_W-5:0], key_code};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) bank_q[i] <= '0;
        end else if (bus.wr_en) begin
            bank_q[bus.addr_wr] <= entry_q;
        end
    end

    assign a_c = bank_q[bus.addr_a];
    assign b_c = bank_q[bus.addr_b];

    always_comb begin
        res_c   = a_c;
        carry_c = 1'b0;
        wide_c  = '0;
        case (bus.op)
            OP_ADD: begin
                wide_c  = {1'b0, a_c} + {1'b0, b_c};
                res_c   = wide_c[DATA_W-1:0];
                carry_c = wide_c[DATA_W];
            end
            OP_SUB: begin
                wide_c  = {1'b0, a_c} - {1'b0, b_c};
                res_c   = wide_c[DATA_W-1:0];
                carry_c = wide_c[DATA_W];
            end
            OP_AND: res_c = a_c & b_c;
            OP_OR:  res_c = a_c | b_c;
            OP_XOR: res_c = a_c ^ b_c;
            OP_SHL: begin
                res_c   = {a_c[DATA_W-2:0], 1'b0};
                carry_c = a_c[DATA_W-1];
            end
            OP_SHR: begin
                res_c   = {1'b0, a_c[DATA_W-1:1]};
                carry_c = a_c[0];
            end
            default: res_c = a_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            alu_q   <= res_c;
            carry_q <= carry_c;
            zero_q  <= (res_c == '0);
        end
    end

    assign bus.entry   = entry_q;
    assign bus.alu_out = alu_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = zero_q;

endmodule
